// File: rtl/pipeline_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_if
// Purpose  : Instruction-fetch stage and IF/ID pipeline register of the
//            5-stage MIPS pipeline. Holds the PC, addresses instruction
//            memory, captures the fetched word, and applies ID-stage
//            redirects (branch, jump, jump-register, interrupt, exception),
//            load-use stalls and squashes. The PC kernel bit (bit 31) is
//            protected: sequential increment never carries into it and JR
//            may clear it but never set it.
// Ports    : clk            - clock, all state updates on rising edge
//            reset          - synchronous active-low reset
//            stall          - hold PC and IF/ID this cycle
//            PCSrc          - next-PC select from ID (6/7 behave as 0)
//            IFID_flush     - branch taken indication from ID
//            ConBA          - branch target from ID
//            JT             - jump index field of the ID instruction
//            JR_target      - forwarded rs value for JR/JALR
//            inst_addr      - instruction memory address (= PC)
//            inst_data      - instruction memory read data (combinational)
//            ID_PC          - address of the instruction in IF/ID
//            ID_instruction - instruction held in IF/ID
//            ID_valid       - 1 = real instruction, 0 = bubble
//            PC31           - kernel-mode bit of ID_PC
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_if #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] ILLOP_ADDR = 32'h8000_0004,
  parameter logic [31:0] XADR_ADDR  = 32'h8000_0008,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  PCSrc,
  input  logic        IFID_flush,
  input  logic [31:0] ConBA,
  input  logic [25:0] JT,
  input  logic [31:0] JR_target,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_instruction,
  output logic        ID_valid,
  output logic        PC31
);

  localparam logic [2:0] c_SRC_BRANCH = 3'd1;
  localparam logic [2:0] c_SRC_JUMP   = 3'd2;
  localparam logic [2:0] c_SRC_JR     = 3'd3;
  localparam logic [2:0] c_SRC_ILLOP  = 3'd4;
  localparam logic [2:0] c_SRC_XADR   = 3'd5;

  logic [31:0] r_pc_q,    w_pc_d;
  logic [31:0] r_idpc_q,  w_idpc_d;
  logic [31:0] r_inst_q,  w_inst_d;
  logic        r_valid_q, w_valid_d;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_seq;

  // Increment only the low 31 bits so the kernel bit is never carried into.
  assign w_pc_seq = {r_pc_q[31], r_pc_q[30:0] + 31'd4};

  // Redirect decision and target. A bubble in ID never redirects, so an
  // interrupt flagged on a bubble waits for the next real instruction.
  always_comb begin
    w_redirect = 1'b0;
    w_target   = w_pc_seq;
    case (PCSrc)
      c_SRC_BRANCH: begin
        w_redirect = r_valid_q & IFID_flush;
        w_target   = ConBA;
      end
      c_SRC_JUMP: begin
        w_redirect = r_valid_q;
        w_target   = {r_idpc_q[31:28], JT, 2'b00};
      end
      c_SRC_JR: begin
        // JR can drop out of kernel mode but can never enter it.
        w_redirect = r_valid_q;
        w_target   = {r_idpc_q[31] & JR_target[31], JR_target[30:0]};
      end
      c_SRC_ILLOP: begin
        w_redirect = r_valid_q;
        w_target   = ILLOP_ADDR;
      end
      c_SRC_XADR: begin
        w_redirect = r_valid_q;
        w_target   = XADR_ADDR;
      end
      default: begin
        w_redirect = 1'b0;
        w_target   = w_pc_seq;
      end
    endcase
  end

  // Next state: stall freezes everything (ID operands are not yet valid,
  // so a redirect is re-evaluated on the first unstalled cycle); a redirect
  // squashes the wrong-path fetch into a bubble.
  always_comb begin
    w_pc_d    = r_pc_q;
    w_idpc_d  = r_idpc_q;
    w_inst_d  = r_inst_q;
    w_valid_d = r_valid_q;
    if (!stall) begin
      if (w_redirect) begin
        w_pc_d    = w_target;
        w_idpc_d  = 32'h0000_0000;
        w_inst_d  = NOP_INST;
        w_valid_d = 1'b0;
      end else begin
        w_pc_d    = w_pc_seq;
        w_idpc_d  = r_pc_q;
        w_inst_d  = inst_data;
        w_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc_q    <= RESET_PC;
      r_idpc_q  <= 32'h0000_0000;
      r_inst_q  <= NOP_INST;
      r_valid_q <= 1'b0;
    end else begin
      r_pc_q    <= w_pc_d;
      r_idpc_q  <= w_idpc_d;
      r_inst_q  <= w_inst_d;
      r_valid_q <= w_valid_d;
    end
  end

  assign inst_addr      = r_pc_q;
  assign ID_PC          = r_idpc_q;
  assign ID_instruction = r_inst_q;
  assign ID_valid       = r_valid_q;
  assign PC31           = r_idpc_q[31];

endmodule
`default_nettype wire

// File: tb/tb_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_if
// Purpose  : Self-checking bench for pipeline_if. Directed scenarios followed
//            by randomized stimulus, all compared against a behavioural
//            model of the fetch stage kept in the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_if;

  localparam logic [31:0] c_RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] c_ILLOP_ADDR = 32'h8000_0004;
  localparam logic [31:0] c_XADR_ADDR  = 32'h8000_0008;
  localparam logic [31:0] c_NOP        = 32'h0000_0000;
  localparam logic [31:0] c_SALT       = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  PCSrc = 3'd0;
  logic        IFID_flush = 1'b0;
  logic [31:0] ConBA = 32'h0;
  logic [25:0] JT = 26'h0;
  logic [31:0] JR_target = 32'h0;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] ID_PC;
  logic [31:0] ID_instruction;
  logic        ID_valid;
  logic        PC31;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_idpc, m_inst;
  logic        m_valid;

  always #5 clk = ~clk;

  // Instruction memory: a scrambled copy of the address so data and address
  // can never be confused.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ c_SALT;
  endfunction

  assign inst_data = mem_word(inst_addr);

  pipeline_if dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .PCSrc          (PCSrc),
    .IFID_flush     (IFID_flush),
    .ConBA          (ConBA),
    .JT             (JT),
    .JR_target      (JR_target),
    .inst_addr      (inst_addr),
    .inst_data      (inst_data),
    .ID_PC          (ID_PC),
    .ID_instruction (ID_instruction),
    .ID_valid       (ID_valid),
    .PC31           (PC31)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, clock the DUT, compare.
  task automatic step(input logic rst_n, input logic stl, input logic [2:0] src,
                      input logic fl, input logic [31:0] cba, input logic [25:0] jt,
                      input logic [31:0] jr);
    logic [31:0] tgt;
    logic        redir;
    reset = rst_n; stall = stl; PCSrc = src; IFID_flush = fl;
    ConBA = cba; JT = jt; JR_target = jr;

    if (!rst_n) begin
      m_pc = c_RESET_PC; m_idpc = 32'h0; m_inst = c_NOP; m_valid = 1'b0;
    end else if (!stl) begin
      redir = m_valid && ((src == 3'd1 && fl) || (src >= 3'd2 && src <= 3'd5));
      tgt = 32'h0;
      if (src == 3'd1) tgt = cba;
      if (src == 3'd2) tgt = (m_idpc & 32'hF000_0000) | ({6'd0, jt} * 4);
      if (src == 3'd3) tgt = (jr & 32'h7FFF_FFFF) | (m_idpc & jr & 32'h8000_0000);
      if (src == 3'd4) tgt = c_ILLOP_ADDR;
      if (src == 3'd5) tgt = c_XADR_ADDR;
      if (redir) begin
        m_pc = tgt; m_idpc = 32'h0; m_inst = c_NOP; m_valid = 1'b0;
      end else begin
        m_inst  = mem_word(m_pc);
        m_idpc  = m_pc;
        m_valid = 1'b1;
        m_pc    = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
      end
    end

    @(posedge clk);
    #1;
    check("inst_addr", inst_addr, m_pc);
    check("ID_PC", ID_PC, m_idpc);
    check("ID_instruction", ID_instruction, m_inst);
    check("ID_valid", {31'd0, ID_valid}, {31'd0, m_valid});
    check("PC31", {31'd0, PC31}, {31'd0, m_idpc[31]});
  endtask

  task automatic seq();
    step(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
  endtask

  initial begin
    m_pc = 32'h0; m_idpc = 32'h0; m_inst = 32'h0; m_valid = 1'b0;

    // Reset, then free-run
    step(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
    check("rst_addr", inst_addr, 32'h8000_0000);
    check("rst_valid", {31'd0, ID_valid}, 32'd0);
    seq();
    check("run1_addr", inst_addr, 32'h8000_0004);
    check("run1_idpc", ID_PC, 32'h8000_0000);
    seq();
    check("run2_addr", inst_addr, 32'h8000_0008);
    seq();

    // JR out of kernel to user address 0x10, then taken branch to 0x40
    step(1'b1, 1'b0, 3'd3, 1'b0, 32'h0, 26'h0, 32'h0000_0010);
    seq();
    check("at10_idpc", ID_PC, 32'h0000_0010);
    step(1'b1, 1'b0, 3'd1, 1'b1, 32'h0000_0040, 26'h0, 32'h0);
    check("br_addr", inst_addr, 32'h0000_0040);
    check("br_bubble", {31'd0, ID_valid}, 32'd0);
    seq();
    check("br_idpc", ID_PC, 32'h0000_0040);

    // Not-taken branch: sequential, no bubble
    step(1'b1, 1'b0, 3'd1, 1'b0, 32'h0000_0800, 26'h0, 32'h0);
    check("nt_addr", inst_addr, 32'h0000_0048);

    // JR from user mode cannot enter kernel
    step(1'b1, 1'b0, 3'd3, 1'b0, 32'h0, 26'h0, 32'h8000_0200);
    check("jr_user", inst_addr, 32'h0000_0200);
    seq();

    // Into kernel via ILLOP, JR stays kernel, then JR leaves kernel
    step(1'b1, 1'b0, 3'd4, 1'b0, 32'h0, 26'h0, 32'h0);
    seq();
    step(1'b1, 1'b0, 3'd3, 1'b0, 32'h0, 26'h0, 32'h8000_0500);
    check("jr_kern", inst_addr, 32'h8000_0500);
    seq();
    step(1'b1, 1'b0, 3'd3, 1'b0, 32'h0, 26'h0, 32'h0000_0300);
    check("jr_leave", inst_addr, 32'h0000_0300);
    seq();

    // Stall two cycles with a jump held in ID, then release
    step(1'b1, 1'b1, 3'd2, 1'b0, 32'h0, 26'h000_0010, 32'h0);
    step(1'b1, 1'b1, 3'd2, 1'b0, 32'h0, 26'h000_0010, 32'h0);
    check("stall_addr", inst_addr, 32'h0000_0304);
    step(1'b1, 1'b0, 3'd2, 1'b0, 32'h0, 26'h000_0010, 32'h0);
    check("jmp_addr", inst_addr, 32'h0000_0040);

    // IRQ on a bubble is deferred, then taken on the next valid instruction
    step(1'b1, 1'b0, 3'd4, 1'b0, 32'h0, 26'h0, 32'h0);
    check("irq_bubble", inst_addr, 32'h0000_0044);
    step(1'b1, 1'b0, 3'd4, 1'b0, 32'h0, 26'h0, 32'h0);
    check("irq_taken", inst_addr, 32'h8000_0004);
    seq();
    step(1'b1, 1'b0, 3'd5, 1'b0, 32'h0, 26'h0, 32'h0);
    check("xadr", inst_addr, 32'h8000_0008);

    // Reset asserted mid-stall
    seq();
    step(1'b1, 1'b1, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
    step(1'b0, 1'b1, 3'd2, 1'b0, 32'h0, 26'h0, 32'h0);
    check("rst_stall", inst_addr, 32'h8000_0000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0),
           ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           $urandom,
           26'($urandom),
           $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_if.md
# pipeline_if

Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipelined MIPS CPU. It holds the PC, drives the instruction-memory address and captures the fetched word. It is the producer side of the ID stage: it consumes the redirect information the ID stage returns (PCSrc, IFID_flush, ConBA, JT, jump-register target) and applies stalls, squashes and kernel-bit protection on the next fetch.

## Interface
- RESET_PC, 32'h8000_0000, PC value after reset (kernel mode)
- ILLOP_ADDR, 32'h8000_0004, interrupt handler entry
- XADR_ADDR, 32'h8000_0008, exception handler entry
- NOP_INST, 32'h0000_0000, word loaded into IF/ID on squash

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk
- stall  in  1  load-use hazard from the hazard unit; holds PC and IF/ID
- PCSrc  in  3  next-PC select from ID control: 0 seq, 1 branch, 2 J/JAL, 3 JR/JALR, 4 ILLOP, 5 XADR, 6/7 treated as 0
- IFID_flush  in  1  branch-taken indication from ID
- ConBA  in  32  branch target computed in ID
- JT  in  26  jump index field of the ID instruction
- JR_target  in  32  forwarded rs value of the ID instruction
- inst_addr  out  32  instruction-memory address (= current PC)
- inst_data  in  32  instruction-memory read data, combinational from inst_addr
- ID_PC  out  32  address of the instruction held in IF/ID
- ID_instruction  out  32  instruction held in IF/ID
- ID_valid  out  1  1 = IF/ID holds a real instruction; 0 = bubble
- PC31  out  1  kernel-mode bit of ID_PC

## Operation
- State: PC register, IF/ID register {ID_PC, ID_instruction, ID_valid}.
- redirect = ID_valid & ((PCSrc==1 & IFID_flush) | PCSrc==2..5). A bubble never redirects; an IRQ marked on a bubble is deferred to the next valid instruction.
- Target by PCSrc:
  - 1: ConBA
  - 2: {ID_PC[31:28], JT, 2'b00}
  - 3: {ID_PC[31] & JR_target[31], JR_target[30:0]}. JR may leave kernel mode but never enter it.
  - 4: ILLOP_ADDR
  - 5: XADR_ADDR
- Sequential next PC = {PC[31], PC[30:0]+4}. The kernel bit is never carried into by the increment; PC[30:0] wraps modulo 2^31.
- PCSrc==1 with IFID_flush=0: branch not taken; sequential fetch; no squash.
- Priority per edge, highest first:
  - reset low: PC<=RESET_PC, ID_PC<=0, ID_instruction<=NOP_INST, ID_valid<=0.
  - stall: PC and the IF/ID register hold; any redirect is ignored this cycle (ID operands not yet valid); it is re-evaluated on the first unstalled cycle.
  - redirect: PC<=target, ID_instruction<=NOP_INST, ID_PC<=0, ID_valid<=0. The wrong-path fetch is squashed; there is no delay slot.
  - otherwise: PC<=PC+4, ID_instruction<=inst_data, ID_PC<=PC, ID_valid<=1.
- PC31 = ID_PC[31].
- inst_addr = PC, combinational from the register.

## Timing
- Fetch-to-ID latency: 1 cycle. A word addressed in cycle n appears on ID_instruction in cycle n+1.
- Redirect resolved in ID in cycle n: the target is fetched in cycle n+1 and appears in ID in cycle n+2. Branch/jump penalty is exactly 1 bubble.
- Stall held k cycles: PC and IF/ID are frozen for exactly k edges. The inst_data sampled on the release edge belongs to the frozen PC.
- Reset: all outputs take their reset values on the first edge with reset low. Reset low during a stall or redirect overrides both. On the first edge after reset rises, RESET_PC is captured into ID_PC with ID_valid=1.
- Back-to-back redirects are impossible: the cycle after a redirect holds a bubble, and bubbles never redirect.

## Test plan
- Reset then free-run, memory word = address: inst_addr 8000_0000, 8000_0004, 8000_0008 on successive cycles; ID_PC lags by 1 cycle; ID_valid=0 for exactly the reset cycle.
- Taken branch: ID_PC=0000_0010, PCSrc=1, IFID_flush=1, ConBA=0000_0040 -> next inst_addr 0000_0040, next ID_instruction=0, ID_valid=0, then ID_PC=0000_0040 valid.
- Not-taken branch: PCSrc=1, IFID_flush=0 at PC 0000_0014 -> inst_addr 0000_0018, no bubble.
- JR kernel protection: ID_PC=0000_0100, PCSrc=3, JR_target=8000_0200 -> inst_addr 0000_0200. From ID_PC=8000_0100, JR_target=0000_0300 -> inst_addr 0000_0300.
- Stall 2 cycles with PCSrc=2 and JT=0x0000010 held on ID -> PC frozen 2 cycles, then inst_addr {ID_PC[31:28], 0x0000040}.
- IRQ on a bubble (PCSrc=4, ID_valid=0) -> sequential fetch; PCSrc=4 on the next valid instruction -> inst_addr 8000_0004. Reset asserted mid-stall -> inst_addr 8000_0000 next edge.
